// File: rtl/kb_uart_tx_if.sv
// rtl/kb_uart_tx_if.sv - write-side bus of the kb_uart_tx scan-code transmitter
interface kb_uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_tick;
   logic       fifo_full;
   logic       fifo_empty;
   logic       overflow;

   modport master (
      output tx_data,
      output tx_tick,
      input  fifo_full,
      input  fifo_empty,
      input  overflow
   );

   modport slave (
      input  tx_data,
      input  tx_tick,
      output fifo_full,
      output fifo_empty,
      output overflow
   );
endinterface

// File: rtl/kb_uart_tx.sv
// rtl/kb_uart_tx.sv - buffered 8N1 UART transmitter, optional even parity via KB_UART_TX_PARITY_EN
module kb_uart_tx #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int ADDR_W       = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic           clk,
   input  logic           reset,
   kb_uart_tx_if.slave    bus,
   output logic           tx,
   output logic           tx_busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef KB_UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t            state;
   logic [TW-1:0]     timer;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;
`ifdef KB_UART_TX_PARITY_EN
   logic              parity;
`endif

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_nxt;
   logic              pop;
   logic              wr_en;

   // The FSM only looks at the registered empty flag, so a fresh write is never bypassed.
   assign pop   = (state == S_IDLE) && !bus.fifo_empty;
   // A full FIFO still takes a write when the head leaves on the same edge.
   assign wr_en = bus.tx_tick && (!bus.fifo_full || pop);

   // Next occupancy, feeding the registered full/empty decode.
   always_comb begin
      count_nxt = count;
      case ({wr_en, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // FIFO storage; contents are meaningless until the pointers say otherwise.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= bus.tx_data;
      end
   end

   // FIFO pointers, occupancy, status flags and the sticky drop flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         bus.fifo_full  <= 1'b0;
         bus.fifo_empty <= 1'b1;
         bus.overflow   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count          <= count_nxt;
         bus.fifo_full  <= (count_nxt == (ADDR_W+1)'(DEPTH));
         bus.fifo_empty <= (count_nxt == '0);
         if (bus.tx_tick && !wr_en) begin
            bus.overflow <= 1'b1;
         end
      end
   end

   // Frame FSM: pops a byte in IDLE and walks start, data, parity, stop with registered tx/tx_busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
`ifdef KB_UART_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               if (pop) begin
                  shift   <= mem[rd_ptr];
`ifdef KB_UART_TX_PARITY_EN
                  parity  <= ^mem[rd_ptr];
`endif
                  timer   <= '0;
                  state   <= S_START;
                  tx      <= 1'b0;
                  tx_busy <= 1'b1;
               end
            end
            S_START: begin
               if (timer == TMAX) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  state   <= S_DATA;
                  tx      <= shift[0];
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_DATA: begin
               if (timer == TMAX) begin
                  timer <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
`ifdef KB_UART_TX_PARITY_EN
                     state   <= S_PARITY;
                     tx      <= parity;
`else
                     state   <= S_STOP;
                     tx      <= 1'b1;
`endif
                  end else begin
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
`ifdef KB_UART_TX_PARITY_EN
            S_PARITY: begin
               if (timer == TMAX) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  state   <= S_STOP;
                  tx      <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
`endif
            S_STOP: begin
               // bit_idx counts stop bits here so the bit timer stays one bit long.
               if (timer == TMAX) begin
                  timer <= '0;
                  if (bit_idx == LAST_STOP) begin
                     bit_idx <= '0;
                     state   <= S_IDLE;
                     tx      <= 1'b1;
                     tx_busy <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               tx      <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kb_uart_tx.sv
// tb/tb_kb_uart_tx.sv - scoreboard bench for kb_uart_tx (CLKS_PER_BIT=4, ADDR_W=2)
module tb_kb_uart_tx;

   localparam int CPB = 4;
   localparam int AW  = 2;
   localparam int SB  = 1;
`ifdef KB_UART_TX_PARITY_EN
   localparam int NB  = 11;
`else
   localparam int NB  = 10;
`endif
   localparam int FRAME = NB * CPB;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       framing_ok;
      int         busy_len;
      int         start_cyc;
   } rx_t;

   logic clk;
   logic reset;
   logic tx;
   logic tx_busy;

   kb_uart_tx_if bus();

   kb_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .ADDR_W       (AW),
      .STOP_BITS    (SB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .tx      (tx),
      .tx_busy (tx_busy)
   );

   int         pass_cnt  = 0;
   int         total_cnt = 0;
   logic [7:0] exp_q[$];
   rx_t        rx_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Line receiver: samples mid-bit and pushes each completed frame into rx_q.
   int   cyc = 0;
   int   mon_t = 0;
   bit   mon_active = 1'b0;
   logic tx_prev = 1'b1;
   rx_t  cur;
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         mon_active = 1'b0;
      end else if (!mon_active && tx_prev === 1'b1 && tx === 1'b0) begin
         mon_active     = 1'b1;
         mon_t          = 0;
         cur.data       = 8'h00;
         cur.par        = 1'b0;
         cur.framing_ok = 1'b1;
         cur.busy_len   = 0;
         cur.start_cyc  = cyc;
      end
      if (mon_active && !reset) begin
         if (tx_busy === 1'b1) cur.busy_len++;
         if (mon_t % CPB == CPB / 2) begin
            int k;
            k = mon_t / CPB;
            if (k == 0) begin
               if (tx !== 1'b0) cur.framing_ok = 1'b0;
            end else if (k <= 8) begin
               cur.data[k-1] = tx;
            end else if (k < NB - SB) begin
               cur.par = tx;
            end else if (tx !== 1'b1) begin
               cur.framing_ok = 1'b0;
            end
         end
         if (mon_t == FRAME - 1) begin
            rx_q.push_back(cur);
            mon_active = 1'b0;
         end
         mon_t++;
      end
      tx_prev = tx;
   end

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.tx_tick = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      rx_q.delete();
      @(negedge clk);
   endtask

   task automatic wait_rx(input int n, input int budget, output bit ok);
      int t;
      t = 0;
      while (rx_q.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      ok = (rx_q.size() >= n);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.tx_tick = 1'b0;
      bus.tx_data = 8'h00;
      repeat (2) @(negedge clk);
      total_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else pass_cnt++;
      total_cnt++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else pass_cnt++;
      total_cnt++; if (bus.fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.fifo_empty); else pass_cnt++;
      total_cnt++; if (bus.fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.fifo_full); else pass_cnt++;
      total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else pass_cnt++;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      bit  ok;
      rx_t r;
      apply_reset();
      bus.tx_data = 8'h1C;
      bus.tx_tick = 1'b1;
      exp_q.push_back(8'h1C);
      @(negedge clk);
      bus.tx_tick = 1'b0;
      total_cnt++; if (bus.fifo_empty !== 1'b0) $display("FAIL single_empty_fall: got %b want 0", bus.fifo_empty); else pass_cnt++;
      total_cnt++; if (tx !== 1'b1) $display("FAIL single_tx_idle_n: got %b want 1", tx); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (tx !== 1'b0) $display("FAIL single_tx_start: got %b want 0", tx); else pass_cnt++;
      total_cnt++; if (tx_busy !== 1'b1) $display("FAIL single_busy_rise: got %b want 1", tx_busy); else pass_cnt++;
      total_cnt++; if (bus.fifo_empty !== 1'b1) $display("FAIL single_empty_rise: got %b want 1", bus.fifo_empty); else pass_cnt++;
      wait_rx(1, FRAME + 20, ok);
      total_cnt++;
      if (!ok) $display("FAIL single_timeout: got %0d frames want 1", rx_q.size());
      else begin
         pass_cnt++;
         r = rx_q.pop_front();
         total_cnt++; if (r.data !== exp_q[0]) $display("FAIL single_data: got %h want %h", r.data, exp_q[0]); else pass_cnt++;
         total_cnt++; if (r.framing_ok !== 1'b1) $display("FAIL single_framing: got %b want 1", r.framing_ok); else pass_cnt++;
         total_cnt++; if (r.busy_len != FRAME) $display("FAIL single_busy_len: got %0d want %0d", r.busy_len, FRAME); else pass_cnt++;
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      total_cnt++; if (tx_busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", tx_busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bit         ok;
      rx_t        r [3];
      logic [7:0] bytes [3];
      bytes[0] = 8'hF0; bytes[1] = 8'h58; bytes[2] = 8'hE0;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         bus.tx_data = bytes[i];
         bus.tx_tick = 1'b1;
         exp_q.push_back(bytes[i]);
         @(negedge clk);
      end
      bus.tx_tick = 1'b0;
      wait_rx(3, 3 * (FRAME + 1) + 20, ok);
      total_cnt++;
      if (!ok) $display("FAIL b2b_timeout: got %0d frames want 3", rx_q.size());
      else begin
         pass_cnt++;
         for (int i = 0; i < 3; i++) begin
            r[i] = rx_q.pop_front();
            total_cnt++; if (r[i].data !== exp_q[0]) $display("FAIL b2b_data%0d: got %h want %h", i, r[i].data, exp_q[0]); else pass_cnt++;
            total_cnt++; if (r[i].framing_ok !== 1'b1) $display("FAIL b2b_framing%0d: got %b want 1", i, r[i].framing_ok); else pass_cnt++;
            void'(exp_q.pop_front());
         end
         for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (r[i+1].start_cyc - r[i].start_cyc != FRAME + 1)
               $display("FAIL b2b_gap%0d: got %0d cycles want %0d", i, r[i+1].start_cyc - r[i].start_cyc, FRAME + 1);
            else pass_cnt++;
         end
      end
      total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL b2b_overflow: got %b want 0", bus.overflow); else pass_cnt++;
   endtask

   task automatic test_overflow();
      bit  ok;
      rx_t r;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         bus.tx_data = 8'h10 + 8'(i);
         bus.tx_tick = 1'b1;
         if (i < 5) exp_q.push_back(8'h10 + 8'(i));
         @(negedge clk);
      end
      bus.tx_tick = 1'b0;
      total_cnt++; if (bus.fifo_full !== 1'b1) $display("FAIL ovf_full: got %b want 1", bus.fifo_full); else pass_cnt++;
      total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", bus.overflow); else pass_cnt++;
      wait_rx(5, 5 * (FRAME + 1) + 20, ok);
      total_cnt++;
      if (!ok) $display("FAIL ovf_timeout: got %0d frames want 5", rx_q.size());
      else pass_cnt++;
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         r = rx_q.pop_front();
         total_cnt++; if (r.data !== exp_q[0]) $display("FAIL ovf_data: got %h want %h", r.data, exp_q[0]); else pass_cnt++;
         void'(exp_q.pop_front());
      end
      repeat (FRAME + 10) @(negedge clk);
      total_cnt++; if (rx_q.size() != 0) $display("FAIL ovf_extra_frames: got %0d want 0", rx_q.size()); else pass_cnt++;
      total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.overflow); else pass_cnt++;
   endtask

   task automatic test_full_pop();
      bit  ok;
      bit  hit;
      rx_t r;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         bus.tx_data = 8'hA0 + 8'(i);
         bus.tx_tick = 1'b1;
         exp_q.push_back(8'hA0 + 8'(i));
         @(negedge clk);
      end
      bus.tx_tick = 1'b0;
      hit = 1'b0;
      for (int t = 0; t < 2 * FRAME && !hit; t++) begin
         @(negedge clk);
         if (tx_busy === 1'b0 && bus.fifo_full === 1'b1) hit = 1'b1;
      end
      total_cnt++;
      if (!hit) $display("FAIL fullpop_no_pop_cycle: got busy=%b full=%b want 0/1", tx_busy, bus.fifo_full);
      else pass_cnt++;
      bus.tx_data = 8'h5A;
      bus.tx_tick = 1'b1;
      exp_q.push_back(8'h5A);
      @(negedge clk);
      bus.tx_tick = 1'b0;
      total_cnt++; if (bus.fifo_full !== 1'b1) $display("FAIL fullpop_full: got %b want 1", bus.fifo_full); else pass_cnt++;
      total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL fullpop_overflow: got %b want 0", bus.overflow); else pass_cnt++;
      wait_rx(6, 6 * (FRAME + 1) + 20, ok);
      total_cnt++;
      if (!ok) $display("FAIL fullpop_timeout: got %0d frames want 6", rx_q.size());
      else pass_cnt++;
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         r = rx_q.pop_front();
         total_cnt++; if (r.data !== exp_q[0]) $display("FAIL fullpop_data: got %h want %h", r.data, exp_q[0]); else pass_cnt++;
         void'(exp_q.pop_front());
      end
      total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL fullpop_overflow_end: got %b want 0", bus.overflow); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int high_bad;
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         bus.tx_data = (i == 0) ? 8'hA5 : 8'h3C;
         bus.tx_tick = 1'b1;
         @(negedge clk);
      end
      bus.tx_tick = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      total_cnt++; if (tx !== 1'b1) $display("FAIL midrst_tx: got %b want 1", tx); else pass_cnt++;
      total_cnt++; if (tx_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", tx_busy); else pass_cnt++;
      total_cnt++; if (bus.fifo_empty !== 1'b1) $display("FAIL midrst_empty: got %b want 1", bus.fifo_empty); else pass_cnt++;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      rx_q.delete();
      high_bad = 0;
      for (int t = 0; t < 3 * FRAME; t++) begin
         @(negedge clk);
         if (tx !== 1'b1) high_bad++;
      end
      total_cnt++; if (high_bad != 0) $display("FAIL midrst_line_idle: got %0d low cycles want 0", high_bad); else pass_cnt++;
      total_cnt++; if (rx_q.size() != 0) $display("FAIL midrst_frames: got %0d want 0", rx_q.size()); else pass_cnt++;
   endtask

`ifdef KB_UART_TX_PARITY_EN
   task automatic test_parity();
      bit         ok;
      rx_t        r;
      logic [7:0] bytes [2];
      logic       pars [2];
      bytes[0] = 8'h58; pars[0] = 1'b1;
      bytes[1] = 8'h00; pars[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         apply_reset();
         bus.tx_data = bytes[i];
         bus.tx_tick = 1'b1;
         @(negedge clk);
         bus.tx_tick = 1'b0;
         wait_rx(1, FRAME + 20, ok);
         total_cnt++;
         if (!ok) $display("FAIL parity_timeout%0d: got %0d frames want 1", i, rx_q.size());
         else begin
            pass_cnt++;
            r = rx_q.pop_front();
            total_cnt++; if (r.data !== bytes[i]) $display("FAIL parity_data%0d: got %h want %h", i, r.data, bytes[i]); else pass_cnt++;
            total_cnt++; if (r.par !== pars[i]) $display("FAIL parity_bit%0d: got %b want %b", i, r.par, pars[i]); else pass_cnt++;
            total_cnt++; if (r.busy_len != 44) $display("FAIL parity_len%0d: got %0d want 44", i, r.busy_len); else pass_cnt++;
         end
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      bus.tx_tick = 1'b0;
      bus.tx_data = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_reset_mid();
`ifdef KB_UART_TX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
